addsub_serial: RTL and testbench



---
 rtl/addsub_serial_pkg.sv | 10 +
 rtl/addsub_serial_if.sv | 7 +
 rtl/addsub_digit.sv | 12 +
 rtl/addsub_serial.sv | 63 ++++++
 tb/tb_addsub_serial.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/addsub_serial_pkg.sv
// addsub_serial_pkg: shared FSM state encoding and counter width helper
package addsub_serial_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: start/ack handshake, operands and result of the serial adder-subtractor
interface addsub_serial_if #(parameter int WIDTH = 8);
  logic             en, sub, ack, busy, done, cout, ovf;
  logic [WIDTH-1:0] a, b, out;
  modport master (output en, sub, a, b, ack, input busy, done, out, cout, ovf);
  modport slave  (input en, sub, a, b, ack, output busy, done, out, cout, ovf);
endinterface

// File: rtl/addsub_digit.sv
// addsub_digit: DIGIT-bit adder slice with carry out and carry into its MSB
module addsub_digit #(parameter int DIGIT = 1) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor, WIDTH/DIGIT cycles per operation, result held until ack
module addsub_serial import addsub_serial_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  addsub_serial_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] dsum;
  logic             dco, dcm, start, step, last;
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .cin(carry_q),
    .sum(dsum), .cout(dco), .c_msb(dcm)
  );
  always_comb begin
    start   = state_q == IDLE && bus.en;
    step    = state_q == ADD;
    last    = step && cnt_q == CW'(N - 1);
    state_d = state_q == IDLE ? (bus.en ? ADD : IDLE) :
              state_q == ADD  ? (last ? DONE : ADD) :
              state_q == DONE ? (bus.ack ? IDLE : DONE) : IDLE;
    a_d     = start ? bus.a : step ? a_q >> DIGIT : a_q;
    b_d     = start ? (bus.sub ? ~bus.b : bus.b) : step ? b_q >> DIGIT : b_q;
    carry_d = start ? bus.sub : step ? dco : carry_q;
    cnt_d   = start ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    // result fills from the top, so after N digits the LSB digit sits at bit 0
    out_d   = start ? '0 : step ? WIDTH'({dsum, out_q} >> DIGIT) : out_q;
    cout_d  = last ? dco : cout_q;
    ovf_d   = last ? dcm ^ dco : ovf_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  assign bus.busy = state_q == ADD;
  assign bus.done = state_q == DONE;
  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: three DUTs (DIGIT=1,4,2; WIDTH=8) driven in lockstep, checked against vectors and a model
module tb_addsub_serial;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sub = 1'b0, ack = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] busy_v, done_v, cout_v, ovf_v;
  logic [2:0][7:0] out_v;
  int n_cmp = 0, n_bad = 0;

  typedef struct packed {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] o;
    logic       c, v;
  } vec_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : 2;
    addsub_serial_if #(.WIDTH(8)) bus ();
    assign bus.en  = en;
    assign bus.sub = sub;
    assign bus.a   = a;
    assign bus.b   = b;
    assign bus.ack = ack;
    addsub_serial #(.WIDTH(8), .DIGIT(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.cout;
    assign ovf_v[g]  = bus.ovf;
    assign out_v[g]  = bus.out;
  end

  function automatic int nof(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 4;
  endfunction

  function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, i, act, exp);
    end
  endfunction

  // reference: {ovf, cout, out} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int r, sr;
    logic c, v;
    r  = s ? int'(x) - int'(y) : int'(x) + int'(y);
    sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    c  = s ? (x >= y) : (r > 255);
    v  = (sr > 127) || (sr < -128);
    return {v, c, 8'(r)};
  endfunction

  function automatic logic [9:0] res(input int i);
    return {ovf_v[i], cout_v[i], out_v[i]};
  endfunction

  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                        input logic [9:0] exp, input bit ack_hi, input int hold);
    int first[3], nb[3], nd[3];
    logic [9:0] got[3];
    for (int i = 0; i < 3; i++) begin first[i] = -1; nb[i] = 0; nd[i] = 0; got[i] = '0; end
    a = xa; b = xb; sub = xs; en = 1'b1; ack = ack_hi;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      en = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        nb[i] += int'(busy_v[i]);
        if (done_v[i]) begin
          nd[i]++;
          if (first[i] < 0) begin first[i] = k; got[i] = res(i); end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("result", i, 32'(got[i]), 32'(exp));
      chk("done_latency", i, first[i], nof(i));
      chk("busy_cycles", i, nb[i], nof(i));
      chk("done_cycles", i, nd[i], ack_hi ? 1 : 10 - nof(i));
    end
    if (!ack_hi) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        en = (h == 1);
        chk("hold_done", 0, 32'(done_v), 32'h7);
        for (int i = 0; i < 3; i++) chk("hold_result", i, 32'(res(i)), 32'(exp));
      end
      ack = 1'b1; en = 1'b1;
      @(negedge clk);
      chk("ack_release", 0, 32'({busy_v, done_v}), 32'h0);
      ack = 1'b0; en = 1'b0;
      @(negedge clk);
      chk("en_dropped", 0, 32'({busy_v, done_v}), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[8];
    logic [7:0] ra, rb;
    logic rs;
    tv[0] = '{a: 8'd200, b: 8'd100, s: 1'b0, o: 8'h2C, c: 1'b1, v: 1'b0};
    tv[1] = '{a: 8'd100, b: 8'd100, s: 1'b0, o: 8'hC8, c: 1'b0, v: 1'b1};
    tv[2] = '{a: 8'd5,   b: 8'd7,   s: 1'b1, o: 8'hFE, c: 1'b0, v: 1'b0};
    tv[3] = '{a: 8'h80,  b: 8'h01,  s: 1'b1, o: 8'h7F, c: 1'b1, v: 1'b1};
    tv[4] = '{a: 8'h00,  b: 8'h00,  s: 1'b1, o: 8'h00, c: 1'b1, v: 1'b0};
    tv[5] = '{a: 8'hFF,  b: 8'h01,  s: 1'b0, o: 8'h00, c: 1'b1, v: 1'b0};
    tv[6] = '{a: 8'h7F,  b: 8'hFF,  s: 1'b1, o: 8'h80, c: 1'b0, v: 1'b1};
    tv[7] = '{a: 8'h00,  b: 8'h00,  s: 1'b0, o: 8'h00, c: 1'b0, v: 1'b0};
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_result", i, 32'(res(i)), 32'h0);
      chk("rst_flags", i, 32'({busy_v[i], done_v[i]}), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 8; t++)
      run_op(tv[t].a, tv[t].b, tv[t].s, {tv[t].v, tv[t].c, tv[t].o}, t >= 4, (t == 3) ? 5 : 2);
    // abort mid-operation: DIGIT=1 instance has counted 3 digits
    a = 8'hFF; b = 8'hFF; sub = 1'b0; en = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_result", i, 32'(res(i)), 32'h0);
      chk("abort_flags", i, 32'({busy_v[i], done_v[i]}), 32'h0);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02}, 1'b0, 1);
    for (int r = 0; r < 30; r++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rs, model(ra, rb, rs), 1'($urandom), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
